press_ack_counter: RTL and testbench

- Consumer end of the debounced button-press handshake.
- Watches the detector's level-held `wasPressed` flag and counts each press exactly once.
- Acknowledges each press with `ackPress` and waits for `wasPressed` to drop before accepting the next press.
- Drives the display counter value in the DebouncedCounter design, plus a one-cycle count strobe and a sticky handshake-fault flag.

---
 rtl/press_ack_counter.sv | 60 ++++++
 tb/tb_press_ack_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/press_ack_counter.sv
// press_ack_counter: consumes level-held button presses once each, acknowledges them and counts them
module press_ack_counter #(
    parameter int WIDTH       = 4,
    parameter int MAX_COUNT   = 9,
    parameter int WRAP        = 1,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wasPressed,
    input  logic             enable,
    input  logic             countUp,
    input  logic             clear,
    input  logic             clearFault,
    output logic             ackPress,
    output logic [WIDTH-1:0] count,
    output logic             countPulse,
    output logic             fault
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACK   = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);
    localparam logic [TW-1:0] TMO = TW'(ACK_TIMEOUT);
    logic [1:0] state, state_n;
    logic [TW-1:0] tmo, tmo_n;
    logic [WIDTH-1:0] step, count_n;
    logic consume, expired;
    // next-state, count step and timeout bookkeeping; ack and fault are decoded from the next state
    always_comb begin
        consume = state == IDLE && wasPressed && enable;
        expired = state == ACK && wasPressed && tmo + TW'(1) == TMO;
        step = countUp ? (count == MAX ? (WRAP != 0 ? '0 : MAX) : count + WIDTH'(1))
                       : (count == '0 ? (WRAP != 0 ? MAX : '0) : count - WIDTH'(1));
        count_n = clear ? '0 : consume ? step : count;
        state_n = consume ? ACK
                : state == ACK ? (!wasPressed ? IDLE : expired ? FAULT : ACK)
                : state == FAULT && !clearFault ? FAULT : IDLE;
        tmo_n = state == ACK && state_n == ACK ? tmo + TW'(1) : '0;
    end
    // register all state and outputs so nothing reaches the ports combinationally
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tmo        <= '0;
            count      <= '0;
            ackPress   <= 1'b0;
            countPulse <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_n;
            tmo        <= tmo_n;
            count      <= count_n;
            ackPress   <= state_n == ACK;
            countPulse <= consume;
            fault      <= state_n == FAULT;
        end
    end
endmodule

// File: tb/tb_press_ack_counter.sv
// tb_press_ack_counter: scoreboard bench for the press/ack counter, wrapping and saturating builds
module tb_press_ack_counter;
    logic clock, reset, wasPressed, enable, countUp, clear, clearFault, en_s;
    logic ackPress, countPulse, fault, ack_s, pulse_s, fault_s;
    logic [3:0] count, count_s;
    int total, bad, pulses, pulses_s, m;
    int q[$];

    press_ack_counter #(.WIDTH(4), .MAX_COUNT(9), .WRAP(1), .ACK_TIMEOUT(8)) dut (
        .clock(clock), .reset(reset), .wasPressed(wasPressed), .enable(enable),
        .countUp(countUp), .clear(clear), .clearFault(clearFault), .ackPress(ackPress),
        .count(count), .countPulse(countPulse), .fault(fault)
    );

    press_ack_counter #(.WIDTH(4), .MAX_COUNT(9), .WRAP(0), .ACK_TIMEOUT(8)) sat (
        .clock(clock), .reset(reset), .wasPressed(wasPressed), .enable(en_s),
        .countUp(countUp), .clear(clear), .clearFault(clearFault), .ackPress(ack_s),
        .count(count_s), .countPulse(pulse_s), .fault(fault_s)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    function automatic int nxt(input int c, input logic up);
        return up ? (c == 9 ? 0 : c + 1) : (c == 0 ? 9 : c - 1);
    endfunction

    // every wait goes through here so each strobe is checked against the scoreboard
    task automatic tick();
        int e;
        @(negedge clock);
        if (pulse_s) pulses_s++;
        if (countPulse) begin
            pulses++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard: unexpected countPulse, count=%0d required no strobe", count);
            end else begin
                e = q.pop_front();
                if (count !== 4'(e)) begin
                    bad++;
                    $display("FAIL scoreboard: count=%0d required %0d", count, e);
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 0; wasPressed = 0; enable = 1; en_s = 0; countUp = 1; clear = 0; clearFault = 0;
        tick(); tick();
        reset = 1; m = 0; q.delete(); pulses = 0; pulses_s = 0;
        tick();
    endtask

    task automatic press(input string nm);
        int t, ac, pc;
        m = nxt(m, countUp);
        q.push_back(m);
        wasPressed = 1; ac = 0; pc = 0; t = 0;
        do begin
            tick(); t++; ac += ackPress ? 1 : 0; pc += countPulse ? 1 : 0;
        end while (!ackPress && t < 20);
        tick(); ac += ackPress ? 1 : 0; pc += countPulse ? 1 : 0;
        wasPressed = 0; t = 0;
        while (ackPress && t < 20) begin
            tick(); t++; ac += ackPress ? 1 : 0; pc += countPulse ? 1 : 0;
        end
        total++;
        if (ac !== 2) begin bad++; $display("FAIL %s ack_cycles: got %0d required 2", nm, ac); end
        total++;
        if (pc !== 1) begin bad++; $display("FAIL %s pulse_cycles: got %0d required 1", nm, pc); end
    endtask

    task automatic test_reset();
        reset = 1; wasPressed = 0; enable = 1; en_s = 0; countUp = 1; clear = 0; clearFault = 0;
        #2 reset = 0;
        tick();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset count: got %0d required 0", count); end
        total++; if (ackPress !== 1'b0) begin bad++; $display("FAIL reset ack: got %b required 0", ackPress); end
        total++; if (countPulse !== 1'b0) begin bad++; $display("FAIL reset pulse: got %b required 0", countPulse); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset fault: got %b required 0", fault); end
        do_reset();
    endtask

    task automatic test_single();
        press("single");
        total++; if (count !== 4'd1) begin bad++; $display("FAIL single count: got %0d required 1", count); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL single fault: got %b required 0", fault); end
    endtask

    task automatic test_wrap_up();
        do_reset();
        for (int i = 0; i < 9; i++) press("wrap_up");
        total++; if (count !== 4'd9) begin bad++; $display("FAIL wrap_up at9: got %0d required 9", count); end
        press("wrap_up");
        total++; if (count !== 4'd0) begin bad++; $display("FAIL wrap_up wrap: got %0d required 0", count); end
        total++; if (pulses !== 10) begin bad++; $display("FAIL wrap_up strobes: got %0d required 10", pulses); end
    endtask

    task automatic test_down_limit();
        do_reset();
        countUp = 0; en_s = 1;
        press("down");
        en_s = 0; countUp = 1;
        total++; if (count !== 4'd9) begin bad++; $display("FAIL down wrap: got %0d required 9", count); end
        total++; if (count_s !== 4'd0) begin bad++; $display("FAIL down saturate: got %0d required 0", count_s); end
        total++; if (pulses_s !== 1) begin bad++; $display("FAIL down sat_strobe: got %0d required 1", pulses_s); end
    endtask

    task automatic test_enable_gate();
        enable = 0; wasPressed = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (ackPress !== 1'b0 || count !== 4'(m)) begin
                bad++; $display("FAIL gate hold: ack=%b count=%0d required ack=0 count=%0d", ackPress, count, m);
            end
        end
        m = nxt(m, 1'b1); q.push_back(m);
        enable = 1;
        tick();
        total++; if (ackPress !== 1'b1) begin bad++; $display("FAIL gate release ack: got %b required 1", ackPress); end
        wasPressed = 0;
        tick(); tick();
    endtask

    task automatic test_timeout();
        int ac;
        do_reset();
        m = nxt(m, 1'b1); q.push_back(m);
        wasPressed = 1; ac = 0;
        for (int i = 0; i < 12; i++) begin tick(); ac += ackPress ? 1 : 0; end
        total++; if (ac !== 8) begin bad++; $display("FAIL timeout ack_cycles: got %0d required 8", ac); end
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL timeout fault: got %b required 1", fault); end
        ac = 0;
        for (int i = 0; i < 5; i++) begin tick(); ac += ackPress ? 1 : 0; end
        total++; if (ac !== 0) begin bad++; $display("FAIL timeout ignored ack: got %0d required 0", ac); end
        total++; if (count !== 4'(m)) begin bad++; $display("FAIL timeout frozen: got %0d required %0d", count, m); end
        wasPressed = 0; clearFault = 1;
        tick();
        clearFault = 0;
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL clear_fault: got %b required 0", fault); end
        press("after_fault");
        total++; if (count !== 4'd2) begin bad++; $display("FAIL after_fault count: got %0d required 2", count); end
    endtask

    task automatic test_clear_and_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) press("to5");
        total++; if (count !== 4'd5) begin bad++; $display("FAIL clear setup: got %0d required 5", count); end
        clear = 1; wasPressed = 1; m = 0; q.push_back(0);
        tick();
        clear = 0;
        total++; if (ackPress !== 1'b1) begin bad++; $display("FAIL clear ack: got %b required 1", ackPress); end
        total++; if (countPulse !== 1'b1) begin bad++; $display("FAIL clear pulse: got %b required 1", countPulse); end
        wasPressed = 0;
        tick(); tick();
        m = nxt(m, 1'b1); q.push_back(m);
        wasPressed = 1;
        tick();
        #2 reset = 0;
        #1;
        total++;
        if (ackPress !== 1'b0 || count !== 4'd0) begin
            bad++; $display("FAIL async reset: ack=%b count=%0d required ack=0 count=0", ackPress, count);
        end
        tick();
        reset = 1; m = 1; q.push_back(1);
        tick();
        total++; if (ackPress !== 1'b1) begin bad++; $display("FAIL repress ack: got %b required 1", ackPress); end
        wasPressed = 0;
        tick(); tick();
    endtask

    initial begin
        total = 0; bad = 0; pulses = 0; pulses_s = 0; m = 0;
        test_reset();
        test_single();
        test_wrap_up();
        test_down_limit();
        test_enable_gate();
        test_timeout();
        test_clear_and_async_reset();
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL scoreboard drain: %0d left required 0", q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
